// File: rtl/mem_addr_unit_pkg.sv
// Shared types and constants for the memory-address unit: FSM states,
// fault codes, access-size encodings and default exception-vector addresses.
package mem_addr_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [1:0] FLT_NONE        = 2'd0;
  localparam logic [1:0] FLT_MISALIGN    = 2'd1;
  localparam logic [1:0] FLT_ILLEGAL_SEL = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam int unsigned VEC_OPCODE_DEF = 253;
  localparam int unsigned VEC_OVF_DEF    = 254;
  localparam int unsigned VEC_DIVZ_DEF   = 255;

  typedef struct packed {
    logic illegal;
    logic misalign;
  } dec_flags_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address-source select plus alignment check against the
// requested access size; illegal selects decode to address 0.
module mem_addr_decode
  import mem_addr_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned VEC0   = VEC_OPCODE_DEF,
  parameter int unsigned VEC1   = VEC_OVF_DEF,
  parameter int unsigned VEC2   = VEC_DIVZ_DEF
) (
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [N_SRC*ADDR_W-1:0] src_flat_i,
  input  logic [1:0]              size_i,
  output logic [ADDR_W-1:0]       addr_c_o,
  output dec_flags_t              flags_c_o
);

  logic [ADDR_W-1:0] addr;
  logic              illegal;
  logic              misalign;

  // Source mux: datapath inputs first, then the three vector constants.
  always_comb begin
    addr    = '0;
    illegal = 1'b0;
    if (sel_i < SEL_W'(N_SRC)) begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        if (sel_i == SEL_W'(i)) begin
          addr = src_flat_i[i*ADDR_W +: ADDR_W];
        end
      end
    end else if (sel_i == SEL_W'(N_SRC)) begin
      addr = ADDR_W'(VEC0);
    end else if (sel_i == SEL_W'(N_SRC + 1)) begin
      addr = ADDR_W'(VEC1);
    end else if (sel_i == SEL_W'(N_SRC + 2)) begin
      addr = ADDR_W'(VEC2);
    end else begin
      illegal = 1'b1;
    end
  end

  // Reserved size is checked as a word access.
  always_comb begin
    misalign = 1'b0;
    case (size_i)
      SZ_BYTE:          misalign = 1'b0;
      SZ_HALF:          misalign = addr[0];
      SZ_WORD, SZ_RSVD: misalign = |addr[1:0];
    endcase
  end

  assign addr_c_o           = addr;
  assign flags_c_o.illegal  = illegal;
  assign flags_c_o.misalign = misalign;

endmodule

// File: rtl/mem_addr_unit.sv
// Registered memory-address selector with a fixed-latency access sequencer:
// issues one mem_en per legal request, holds the address, then pulses done.
module mem_addr_unit
  import mem_addr_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned VEC0    = VEC_OPCODE_DEF,
  parameter int unsigned VEC1    = VEC_OVF_DEF,
  parameter int unsigned VEC2    = VEC_DIVZ_DEF,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_SRC*ADDR_W-1:0] src_flat,
  input  logic [1:0]              size,
  input  logic                    req,
  output logic                    busy,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    done,
  output logic                    fault,
  output logic [1:0]              fault_code,
  output logic [ADDR_W-1:0]       fault_addr
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;

  logic [ADDR_W-1:0] dec_addr;
  dec_flags_t        dec_flags;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;
  logic              fault_q, fault_d;
  logic              fin_q, fin_d;
  logic              done_q, done_d;

  mem_addr_decode #(
    .ADDR_W (ADDR_W),
    .N_SRC  (N_SRC),
    .SEL_W  (SEL_W),
    .VEC0   (VEC0),
    .VEC1   (VEC1),
    .VEC2   (VEC2)
  ) u_decode (
    .sel_i      (sel),
    .src_flat_i (src_flat),
    .size_i     (size),
    .addr_c_o   (dec_addr),
    .flags_c_o  (dec_flags)
  );

  // Next-state and registered-output logic; done trails the return to IDLE by one cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    fault_addr_d = fault_addr_q;
    fault_code_d = FLT_NONE;
    fin_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (dec_flags.illegal) begin
            state_d      = ST_FAULT;
            fault_code_d = FLT_ILLEGAL_SEL;
            fault_addr_d = dec_addr;
          end else if (dec_flags.misalign) begin
            state_d      = ST_FAULT;
            fault_code_d = FLT_MISALIGN;
            fault_addr_d = dec_addr;
          end else begin
            state_d    = ST_ISSUE;
            mem_addr_d = dec_addr;
            cnt_d      = CNT_W'(MEM_LAT - 1);
          end
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          fin_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d   = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    mem_en_d = (state_d == ST_ISSUE);
    fault_d  = (state_d == ST_FAULT);
    done_d   = fin_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      fault_addr_q <= '0;
      fault_code_q <= FLT_NONE;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      fault_q      <= 1'b0;
      fin_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      fault_addr_q <= fault_addr_d;
      fault_code_q <= fault_code_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      fault_q      <= fault_d;
      fin_q        <= fin_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_addr_unit.sv
// Scoreboard bench for mem_addr_unit: two builds (4x32-bit src with 3-cycle
// latency, 2x16-bit src with 1-cycle latency) driven by the same stimulus.
module tb_mem_addr_unit;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  sel = '0;
  logic [1:0]  size = '0;
  logic        req = 1'b0;
  logic [31:0] src_v [4];
  logic [31:0] src_next [4];

  logic [127:0] src_flat_a;
  logic [31:0]  src_flat_b;
  assign src_flat_a = {src_v[3], src_v[2], src_v[1], src_v[0]};
  assign src_flat_b = {src_v[1][15:0], src_v[0][15:0]};

  logic        a_busy, a_mem_en, a_done, a_fault;
  logic [1:0]  a_fcode;
  logic [31:0] a_mem_addr, a_faddr;
  logic        b_busy, b_mem_en, b_done, b_fault;
  logic [1:0]  b_fcode;
  logic [15:0] b_mem_addr, b_faddr;

  mem_addr_unit #(
    .ADDR_W(32), .N_SRC(4), .SEL_W(3), .VEC0(253), .VEC1(254), .VEC2(255), .MEM_LAT(LAT_A)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src_flat(src_flat_a), .size(size), .req(req),
    .busy(a_busy), .mem_en(a_mem_en), .mem_addr(a_mem_addr), .done(a_done),
    .fault(a_fault), .fault_code(a_fcode), .fault_addr(a_faddr)
  );

  mem_addr_unit #(
    .ADDR_W(16), .N_SRC(2), .SEL_W(3), .VEC0(253), .VEC1(254), .VEC2(255), .MEM_LAT(LAT_B)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src_flat(src_flat_b), .size(size), .req(req),
    .busy(b_busy), .mem_en(b_mem_en), .mem_addr(b_mem_addr), .done(b_done),
    .fault(b_fault), .fault_code(b_fcode), .fault_addr(b_faddr)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    bit          is_fault;
    logic [31:0] addr;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  exp_t        q_acc [2][$];
  int          q_done [2][$];
  int          next_free [2];
  int          busy_lo [2];
  int          busy_hi [2];
  logic [31:0] hold_addr [2];
  logic [31:0] hold_faddr [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, edge_n, act, exp);
  endtask

  // Reference decode straight from the address-map and alignment rules.
  function automatic void model_decode(input int d, input logic [2:0] s, input logic [1:0] sz,
                                       output bit illegal, output bit mis, output logic [31:0] a);
    int          n;
    logic [31:0] mask;
    n    = (d == 0) ? 4 : 2;
    mask = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    illegal = 1'b0;
    a       = '0;
    if (int'(s) < n) a = src_v[s[1:0]] & mask;
    else if (int'(s) < n + 3) a = 32'd253 + 32'(int'(s) - n);
    else illegal = 1'b1;
    mis = !illegal && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00));
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      q_acc[d].delete();
      q_done[d].delete();
      next_free[d]  = 0;
      busy_lo[d]    = 0;
      busy_hi[d]    = -1;
      hold_addr[d]  = '0;
      hold_faddr[d] = '0;
    end
  endfunction

  // One stimulus cycle: apply inputs after negedge and predict each unit's response.
  task automatic drive(input bit r, input logic [2:0] s, input logic [1:0] sz);
    @(negedge clk);
    for (int i = 0; i < 4; i++) src_v[i] = src_next[i];
    req  = r;
    sel  = s;
    size = sz;
    if (r && reset_n) begin
      int e;
      e = edge_n + 1;
      for (int d = 0; d < 2; d++) begin
        if (e >= next_free[d]) begin
          bit          ill, mis;
          logic [31:0] a;
          exp_t        x;
          int          lat;
          lat = (d == 0) ? LAT_A : LAT_B;
          model_decode(d, s, sz, ill, mis, a);
          x.cyc = e;
          if (ill || mis) begin
            x.is_fault = 1'b1;
            x.addr     = a;
            x.code     = ill ? 2'd2 : 2'd1;
            next_free[d] = e + 2;
          end else begin
            x.is_fault = 1'b0;
            x.addr     = a;
            x.code     = 2'd0;
            q_done[d].push_back(e + lat + 1);
            busy_lo[d]   = e;
            busy_hi[d]   = e + lat - 1;
            next_free[d] = e + lat + 1;
          end
          q_acc[d].push_back(x);
        end
      end
    end
  endtask

  task automatic gap(input int n);
    repeat (n) drive(1'b0, 3'd0, 2'd0);
  endtask

  task automatic mon(input int d, input logic b, input logic me, input logic [31:0] ma,
                     input logic dn, input logic f, input logic [1:0] fc, input logic [31:0] fa);
    bit   exp_issue, exp_fault, exp_dn;
    exp_t x;
    exp_issue = 1'b0;
    exp_fault = 1'b0;
    exp_dn    = 1'b0;
    if (q_acc[d].size() > 0 && q_acc[d][0].cyc == edge_n) begin
      x = q_acc[d].pop_front();
      exp_issue = !x.is_fault;
      exp_fault = x.is_fault;
    end
    chk("mem_en", d, 32'(me), 32'(exp_issue));
    chk("fault", d, 32'(f), 32'(exp_fault));
    if (exp_issue) hold_addr[d] = x.addr;
    if (exp_fault) begin
      chk("fault_code", d, 32'(fc), 32'(x.code));
      hold_faddr[d] = x.addr;
    end else begin
      chk("fault_code_idle", d, 32'(fc), 32'd0);
    end
    chk("mem_addr", d, ma, hold_addr[d]);
    chk("fault_addr", d, fa, hold_faddr[d]);
    if (q_done[d].size() > 0 && q_done[d][0] == edge_n) begin
      void'(q_done[d].pop_front());
      exp_dn = 1'b1;
    end
    chk("done", d, 32'(dn), 32'(exp_dn));
    chk("busy", d, 32'(b), 32'(edge_n >= busy_lo[d] && edge_n <= busy_hi[d]));
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, a_busy, a_mem_en, a_mem_addr, a_done, a_fault, a_fcode, a_faddr);
      mon(1, b_busy, b_mem_en, {16'h0, b_mem_addr}, b_done, b_fault, b_fcode, {16'h0, b_faddr});
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 0, 32'(a_busy), 32'd0);
    chk({tag, "_mem_en"}, 0, 32'(a_mem_en), 32'd0);
    chk({tag, "_mem_addr"}, 0, a_mem_addr, 32'd0);
    chk({tag, "_done"}, 0, 32'(a_done), 32'd0);
    chk({tag, "_fault"}, 0, 32'(a_fault), 32'd0);
    chk({tag, "_fault_code"}, 0, 32'(a_fcode), 32'd0);
    chk({tag, "_fault_addr"}, 0, a_faddr, 32'd0);
    chk({tag, "_busy"}, 1, 32'(b_busy), 32'd0);
    chk({tag, "_mem_en"}, 1, 32'(b_mem_en), 32'd0);
    chk({tag, "_mem_addr"}, 1, 32'(b_mem_addr), 32'd0);
    chk({tag, "_done"}, 1, 32'(b_done), 32'd0);
    chk({tag, "_fault"}, 1, 32'(b_fault), 32'd0);
    chk({tag, "_fault_code"}, 1, 32'(b_fcode), 32'd0);
    chk({tag, "_fault_addr"}, 1, 32'(b_faddr), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_v[i]    = '0;
      src_next[i] = '0;
    end
    model_clear();

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Directed: legal word, vectors, misalign and illegal selects.
    src_next[0] = 32'h0000_1002;
    src_next[1] = 32'h0000_1000;
    src_next[2] = 32'h0000_0003;
    src_next[3] = 32'h0000_4000;
    gap(2);
    drive(1'b1, 3'd1, 2'd2); gap(6);
    drive(1'b1, 3'd4, 2'd0); gap(6);
    drive(1'b1, 3'd5, 2'd0); gap(6);
    drive(1'b1, 3'd6, 2'd0); gap(6);
    drive(1'b1, 3'd4, 2'd2); gap(6);
    drive(1'b1, 3'd0, 2'd2); gap(6);
    drive(1'b1, 3'd0, 2'd1); gap(6);
    drive(1'b1, 3'd7, 2'd0); gap(6);
    drive(1'b1, 3'd2, 2'd1); gap(6);

    // Back-to-back: req held high, alternating sources; requests while busy drop.
    for (int k = 0; k < 16; k++) drive(1'b1, (k % 2 == 0) ? 3'd0 : 3'd2, 2'd0);
    gap(6);

    // Asynchronous reset in the middle of a multi-cycle access.
    src_next[1] = 32'h0000_2000;
    drive(1'b1, 3'd1, 2'd2);
    drive(1'b0, 3'd0, 2'd0);
    drive(1'b0, 3'd0, 2'd0);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("abort");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    gap(8);

    // Randomised traffic with a bias toward aligned addresses.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        src_next[i] = $urandom;
        if ($urandom_range(0, 1) == 1) src_next[i][1:0] = 2'b00;
      end
      drive($urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end
    gap(10);

    for (int d = 0; d < 2; d++) begin
      chk("acc_queue_empty", d, 32'(q_acc[d].size()), 32'd0);
      chk("done_queue_empty", d, 32'(q_done[d].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
